// File: rtl/logic_fnct_seq.sv
// Two-key logic-function unit: debounced keys latch switch operands and step through 8 bitwise ops.
// Optional automatic op stepping is built only when LOGIC_FNCT_AUTO_STEP_EN is defined.
module logic_fnct_seq #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int AUTO_PERIOD     = 50000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         KEY,
   input  logic [2*WIDTH-1:0] SW,
   output logic [WIDTH-1:0]   LED,
   output logic [2:0]         op_sel,
   output logic               result_valid
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NOT  = 3'd2,
      OP_XOR  = 3'd3,
      OP_NAND = 3'd4,
      OP_NOR  = 3'd5,
      OP_XNOR = 3'd6,
      OP_ANDN = 3'd7
   } op_e;

   logic [1:0]      sync1;
   logic [1:0]      sync2;
   logic [1:0]      deb;
   logic [1:0]      deb_d;
   logic [1:0]      press;
   logic [DB_W-1:0] db_cnt [2];

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             write_q;
   logic             step;

   function automatic logic [WIDTH-1:0] op_f(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      r = '0;
      case (op_e'(op))
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_NOT:  r = ~a;
         OP_XOR:  r = a ^ b;
         OP_NAND: r = ~(a & b);
         OP_NOR:  r = ~(a | b);
         OP_XNOR: r = ~(a ^ b);
         OP_ANDN: r = a & ~b;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Keys idle high; the debounced level only follows the synced level after DEBOUNCE_CYCLES
   // disagreeing samples, and a press is the registered released->pressed edge of that level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1  <= 2'b11;
         sync2  <= 2'b11;
         deb    <= 2'b11;
         deb_d  <= 2'b11;
         press  <= 2'b00;
         db_cnt <= '{default: '0};
      end else begin
         sync1 <= KEY;
         sync2 <= sync1;
         deb_d <= deb;
         press <= deb_d & ~deb;
         for (int k = 0; k < 2; k++) begin
            if (sync2[k] == deb[k]) begin
               db_cnt[k] <= '0;
            end else if (db_cnt[k] == DB_LAST) begin
               deb[k]    <= sync2[k];
               db_cnt[k] <= '0;
            end else begin
               db_cnt[k] <= db_cnt[k] + 1'b1;
            end
         end
      end
   end

`ifdef LOGIC_FNCT_AUTO_STEP_EN
   localparam int AUTO_W = $clog2(AUTO_PERIOD + 1);
   localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

   logic [AUTO_W-1:0] auto_cnt;
   logic              auto_tc;

   assign auto_tc = (auto_cnt == AUTO_LAST);
   assign step    = press[0] | auto_tc;

   // Restarting on every step keeps a full AUTO_PERIOD between any op change and the next auto step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         auto_cnt <= '0;
      end else if (step) begin
         auto_cnt <= '0;
      end else begin
         auto_cnt <= auto_cnt + 1'b1;
      end
   end
`else
   logic unused_auto_period;

   assign unused_auto_period = |AUTO_PERIOD;
   assign step               = press[0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_sel  <= 3'd0;
         a_q     <= '0;
         b_q     <= '0;
         write_q <= 1'b0;
      end else begin
         write_q <= step | press[1];
         if (step) begin
            op_sel <= op_sel + 3'd1;
         end
         if (press[1]) begin
            a_q <= SW[WIDTH-1:0];
            b_q <= SW[2*WIDTH-1:WIDTH];
         end
      end
   end

   // The strobe trails the op/operand write by one cycle so it lines up with the refreshed LED.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         LED          <= '0;
         result_valid <= 1'b0;
      end else begin
         LED          <= op_f(op_sel, a_q, b_q);
         result_valid <= write_q;
      end
   end

endmodule

// File: tb/tb_logic_fnct_seq.sv
// Scoreboard bench for logic_fnct_seq (WIDTH=4, DEBOUNCE_CYCLES=4): directed key presses push
// expected {op_sel, LED} pairs, a monitor pops one per result_valid strobe.
module tb_logic_fnct_seq;

   localparam int WIDTH = 4;
   localparam int DB    = 4;
   localparam int AP    = 20;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       KEY;
   logic [2*WIDTH-1:0] SW;
   logic [WIDTH-1:0] LED;
   logic [2:0]       op_sel;
   logic             result_valid;

   typedef struct packed {
      logic [2:0] op;
      logic [3:0] led;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [3:0] led_seq [8];

   always #5 clk = ~clk;

   logic_fnct_seq #(
      .WIDTH(WIDTH),
      .DEBOUNCE_CYCLES(DB),
      .AUTO_PERIOD(AP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .KEY(KEY),
      .SW(SW),
      .LED(LED),
      .op_sel(op_sel),
      .result_valid(result_valid)
   );

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
      n_checks++;
      if (actual !== required) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
      end
   endtask

   // keys_pressed bit k = 1 drives KEY[k] low for 'hold' cycles, then waits out the release debounce.
   task automatic apply_stimulus(input logic [1:0] keys_pressed, input int hold, input logic [7:0] sw_val);
      @(negedge clk);
      SW  = sw_val;
      KEY = ~keys_pressed;
      repeat (hold) @(negedge clk);
      KEY = 2'b11;
      repeat (DB + 8) @(negedge clk);
   endtask

   task automatic press_op(input logic [2:0] exp_op, input logic [3:0] exp_led);
      exp_q.push_back('{op: exp_op, led: exp_led});
      apply_stimulus(2'b01, 8, SW);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check_output("unexpected_strobe", {31'b0, result_valid}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check_output("sb_led", {28'b0, LED}, {28'b0, e.led});
               check_output("sb_op_sel", {29'b0, op_sel}, {29'b0, e.op});
            end
         end
      end
   end

   initial begin
      led_seq[0] = 4'h8; led_seq[1] = 4'hE; led_seq[2] = 4'h5; led_seq[3] = 4'h6;
      led_seq[4] = 4'h7; led_seq[5] = 4'h1; led_seq[6] = 4'h9; led_seq[7] = 4'h2;

      rst = 1'b1;
      KEY = 2'b11;
      SW  = '0;
      repeat (3) @(negedge clk);
      check_output("reset_led", {28'b0, LED}, 32'd0);
      check_output("reset_op_sel", {29'b0, op_sel}, 32'd0);
      check_output("reset_result_valid", {31'b0, result_valid}, 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] operand latch latency");
      exp_q.push_back('{op: 3'd0, led: 4'h8});
      @(negedge clk);
      SW  = 8'hCA;
      KEY = 2'b01;
      for (int e = 0; e <= 8; e++) begin
         @(posedge clk);
         #1;
         if (e == 7) check_output("lat_rv_edge7", {31'b0, result_valid}, 32'd0);
         if (e == 8) begin
            check_output("lat_rv_edge8", {31'b0, result_valid}, 32'd1);
            check_output("lat_led_edge8", {28'b0, LED}, 32'h8);
         end
      end
      repeat (2) @(negedge clk);
      KEY = 2'b11;
      repeat (DB + 8) @(negedge clk);

      $display("[TB] op stepping with a=A b=C");
      for (int i = 1; i < 8; i++) press_op(3'(i), led_seq[i]);
      press_op(3'd0, led_seq[0]);

      $display("[TB] short glitches on KEY[0]");
      for (int len = 1; len <= 3; len++) begin
         repeat (2) begin
            @(negedge clk);
            KEY = 2'b10;
            repeat (len) @(negedge clk);
            KEY = 2'b11;
            repeat (6) @(negedge clk);
         end
      end
      check_output("glitch_op_sel", {29'b0, op_sel}, 32'd0);
      check_output("glitch_led", {28'b0, LED}, 32'h8);

      $display("[TB] simultaneous step and latch");
      exp_q.push_back('{op: 3'd1, led: 4'h7});
      apply_stimulus(2'b11, 8, 8'h35);

      @(negedge clk);
      SW = 8'hFF;
      repeat (20) @(negedge clk);
      check_output("sw_no_press_led", {28'b0, LED}, 32'h7);
      check_output("sw_no_press_op_sel", {29'b0, op_sel}, 32'd1);

      $display("[TB] reset mid-debounce with KEY[0] held");
      @(negedge clk);
      KEY = 2'b10;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_output("midrst_led", {28'b0, LED}, 32'd0);
      check_output("midrst_op_sel", {29'b0, op_sel}, 32'd0);
      check_output("midrst_result_valid", {31'b0, result_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back('{op: 3'd1, led: 4'h0});
      repeat (25) @(negedge clk);
      KEY = 2'b11;
      repeat (DB + 8) @(negedge clk);

      for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(negedge clk);
      check_output("queue_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
